nios_core_led: RTL and testbench



---
 rtl/nios_core_led.sv | 104 ++++++++++
 tb/tb_nios_core_led.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nios_core_led.sv
// Avalon-MM LED output port: data register with set/clear aliases and a per-bit
// blink mask driven by a programmable prescaler. Reads have a fixed one-cycle latency.
module nios_core_led #(
    parameter int unsigned                DATA_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0]      RESET_VALUE    = 16'h0000,
    parameter int unsigned                PRESCALE_WIDTH = 24,
    parameter logic [PRESCALE_WIDTH-1:0]  PRESCALE_RESET = 24'd12_499_999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrBlink    = 3'd1;
    localparam logic [2:0] AddrPrescale = 3'd2;
    localparam logic [2:0] AddrStatus   = 3'd3;
    localparam logic [2:0] AddrOutSet   = 3'd4;
    localparam logic [2:0] AddrOutClear = 3'd5;

    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     blink_q, blink_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      phase_q, phase_d;
    logic [31:0]               readdata_d;
    logic [DATA_WIDTH-1:0]     out_port_d;
    logic                      wr_en;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wr_data          = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = ^writedata;

    // Register writes; reserved and read-only addresses fall through unchanged.
    always_comb begin
        data_d     = data_q;
        blink_d    = blink_q;
        prescale_d = prescale_q;
        if (wr_en) begin
            case (address)
                AddrData:     data_d     = wr_data;
                AddrBlink:    blink_d    = wr_data;
                AddrPrescale: prescale_d = writedata[PRESCALE_WIDTH-1:0];
                AddrOutSet:   data_d     = data_q | wr_data;
                AddrOutClear: data_d     = data_q & ~wr_data;
                default:      ;
            endcase
        end
    end

    // A prescale write restarts the blink period and wins over a same-cycle tick.
    always_comb begin
        cnt_d   = cnt_q - PRESCALE_WIDTH'(1);
        phase_d = phase_q;
        if (wr_en && address == AddrPrescale) begin
            cnt_d   = writedata[PRESCALE_WIDTH-1:0];
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = prescale_q;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            AddrData:     readdata_d[DATA_WIDTH-1:0]     = data_q;
            AddrBlink:    readdata_d[DATA_WIDTH-1:0]     = blink_q;
            AddrPrescale: readdata_d[PRESCALE_WIDTH-1:0] = prescale_q;
            AddrStatus:   readdata_d[0]                  = phase_q;
            default:      ;
        endcase
    end

    assign out_port_d = data_q & ~(blink_q & {DATA_WIDTH{phase_q}});

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_q    <= '0;
            prescale_q <= PRESCALE_RESET;
            cnt_q      <= PRESCALE_RESET;
            phase_q    <= 1'b0;
            readdata   <= '0;
            out_port   <= '0;
        end else begin
            data_q     <= data_d;
            blink_q    <= blink_d;
            prescale_q <= prescale_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata   <= readdata_d;
            out_port   <= out_port_d;
        end
    end

endmodule

// File: tb/tb_nios_core_led.sv
// Directed bench for nios_core_led: reset, set/clear aliases, blink timing,
// prescale rewrite, read-during-write and mid-blink reset.
module tb_nios_core_led;

    localparam int unsigned          DW      = 16;
    localparam logic [DW-1:0]        RST_VAL = 16'h00A5;
    localparam logic [23:0]          PS_RST  = 24'd5;

    logic          clk;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    int n_checks = 0;
    int n_fail   = 0;

    nios_core_led #(
        .DATA_WIDTH     (DW),
        .RESET_VALUE    (RST_VAL),
        .PRESCALE_WIDTH (24),
        .PRESCALE_RESET (PS_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset held for two edges.
        tick();
        chk("rst_out_1", {16'h0, out_port}, 32'h0);
        chk("rst_rd_1", readdata, 32'h0);
        tick();
        chk("rst_out_2", {16'h0, out_port}, 32'h0);
        chk("rst_rd_2", readdata, 32'h0);
        reset   = 1'b0;
        address = 3'd2;
        tick();
        chk("rel_out", {16'h0, out_port}, 32'h0000_00A5);
        chk("rel_prescale", readdata, 32'd5);
        // First toggle lands 6 edges after the last reset edge.
        address = 3'd3;
        repeat (5) tick();
        chk("first_tick_pre", readdata, 32'd0);
        tick();
        chk("first_tick_post", readdata, 32'd1);

        // Set/clear aliases.
        do_write(3'd0, 32'h0000_00F0);
        do_write(3'd4, 32'hFFFF_0003);
        chk("sc_out_f0", {16'h0, out_port}, 32'h0000_00F0);
        do_read(3'd0);
        chk("sc_rd_f3", readdata, 32'h0000_00F3);
        chk("sc_out_f3", {16'h0, out_port}, 32'h0000_00F3);
        do_write(3'd5, 32'h0000_0030);
        chk("sc_rd_clr_addr", readdata, 32'h0);
        do_read(3'd0);
        chk("sc_rd_c3", readdata, 32'h0000_00C3);
        chk("sc_out_c3", {16'h0, out_port}, 32'h0000_00C3);
        do_read(3'd4);
        chk("sc_rd_outset", readdata, 32'h0);

        // Blink: prescale 3 gives 4-cycle phases.
        do_write(3'd2, 32'd3);
        do_write(3'd1, 32'h0000_000F);
        do_write(3'd0, 32'h0000_00FF);
        address = 3'd3;
        for (int i = 3; i <= 14; i++) begin
            logic ph;
            tick();
            ph = (((i - 1) / 4) % 2) != 0;
            chk($sformatf("blink_out_%0d", i), {16'h0, out_port},
                ph ? 32'h0000_00F0 : 32'h0000_00FF);
            chk($sformatf("blink_status_%0d", i), readdata, {31'h0, ph});
        end

        // Prescale rewrite while phase=1.
        do_write(3'd2, 32'd9);
        address = 3'd3;
        repeat (11) tick();
        chk("rw_phase_hi", readdata, 32'd1);
        chk("rw_out_dark", {16'h0, out_port}, 32'h0000_00F0);
        do_write(3'd2, 32'd1);
        chk("rw_old_prescale", readdata, 32'd9);
        address = 3'd3;
        tick();
        chk("rw_ph_r1", readdata, 32'd0);
        chk("rw_out_r1", {16'h0, out_port}, 32'h0000_00FF);
        tick();
        chk("rw_ph_r2", readdata, 32'd0);
        tick();
        chk("rw_ph_r3", readdata, 32'd1);
        tick();
        chk("rw_ph_r4", readdata, 32'd1);
        tick();
        chk("rw_ph_r5", readdata, 32'd0);

        // Read-during-write and reserved addresses.
        do_write(3'd0, 32'h0000_1234);
        do_write(3'd0, 32'h0000_5678);
        chk("rdw_old", readdata, 32'h0000_1234);
        do_read(3'd0);
        chk("rdw_new", readdata, 32'h0000_5678);
        do_read(3'd6);
        chk("rsvd6_rd", readdata, 32'h0);
        do_write(3'd7, 32'hFFFF_FFFF);
        do_read(3'd0);
        chk("rsvd7_data", readdata, 32'h0000_5678);
        do_read(3'd1);
        chk("rsvd7_blink", readdata, 32'h0000_000F);
        do_read(3'd2);
        chk("rsvd7_prescale", readdata, 32'd1);

        // Reset while phase=1 and cnt=2.
        do_write(3'd2, 32'd3);
        address = 3'd0;
        repeat (5) tick();
        chk("mid_out_dark", {16'h0, out_port}, 32'h0000_5670);
        reset = 1'b1;
        tick();
        chk("mid_rst_out", {16'h0, out_port}, 32'h0);
        chk("mid_rst_rd", readdata, 32'h0);
        reset = 1'b0;
        tick();
        chk("mid_rel_out", {16'h0, out_port}, 32'h0000_00A5);
        chk("mid_rel_data", readdata, 32'h0000_00A5);
        do_read(3'd1);
        chk("mid_rel_blink", readdata, 32'h0);
        do_read(3'd2);
        chk("mid_rel_prescale", readdata, 32'd5);
        do_read(3'd3);
        chk("mid_rel_phase", readdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
